// File: rtl/viterbi_backtrace.sv
// viterbi_backtrace
//   Traceback end of the Viterbi POS tagger. It stores one backpointer per
//   (time step, state) during the forward pass. On start it walks the pointers
//   back from the final best state and emits the decoded tags last-to-first
//   over a valid/ready stream.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   bp_wr_en/_t/_state/_idx         backpointer write port (dropped while busy)
//   start, seq_len, last_state      traceback request
//   busy                            traceback in progress
//   tag_valid/_ready/_out/_t/_last  decoded tag stream (t counts down to 0)
//   done, err                       one-cycle pulses: finished / bad seq_len
module viterbi_backtrace #(
   parameter int POS_num_bit = 4,
   parameter int T_BITS      = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bp_wr_en,
   input  logic [T_BITS-1:0]      bp_wr_t,
   input  logic [POS_num_bit-1:0] bp_wr_state,
   input  logic [POS_num_bit-1:0] bp_wr_idx,
   input  logic                   start,
   input  logic [T_BITS:0]        seq_len,
   input  logic [POS_num_bit-1:0] last_state,
   output logic                   busy,
   output logic                   tag_valid,
   input  logic                   tag_ready,
   output logic [POS_num_bit-1:0] tag_out,
   output logic [T_BITS-1:0]      tag_t,
   output logic                   tag_last,
   output logic                   done,
   output logic                   err
);
   localparam int NUM_STATES = 2**POS_num_bit;
   localparam int T_MAX      = 2**T_BITS;

   typedef enum logic [1:0] {IDLE, EMIT, FETCH} state_t;

   state_t                   state_q, state_d;
   logic [T_BITS-1:0]        t_q, t_d;
   logic [POS_num_bit-1:0]   cur_q, cur_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     rd_en;
   logic [POS_num_bit-1:0]   rd_q;
   logic [T_BITS:0]          len_m1;

   // Backpointer store, address {t,state}; no reset on contents.
   logic [POS_num_bit-1:0] mem_q [NUM_STATES*T_MAX];

   // Writes are only accepted in IDLE, so a read never collides with a write.
   always_ff @(posedge clk) begin
      if (bp_wr_en && (state_q == IDLE))
         mem_q[{bp_wr_t, bp_wr_state}] <= bp_wr_idx;
      if (rd_en)
         rd_q <= mem_q[{t_q, cur_q}];
   end

   assign len_m1 = seq_len - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         cur_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         cur_q   <= cur_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      cur_d   = cur_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (seq_len == '0) begin
                  done_d = 1'b1;
               end else if (seq_len > (T_BITS+1)'(T_MAX)) begin
                  err_d = 1'b1;
               end else begin
                  t_d     = len_m1[T_BITS-1:0];
                  cur_d   = last_state;
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (tag_ready) begin
               if (t_q == '0) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  // Pointer at {t,cur} names the state at t-1.
                  rd_en   = 1'b1;
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            cur_d   = rd_q;
            t_d     = t_q - 1'b1;
            state_d = EMIT;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign tag_valid = (state_q == EMIT);
   assign tag_out   = cur_q;
   assign tag_t     = t_q;
   assign tag_last  = tag_valid && (t_q == '0);
   assign done      = done_q;
   assign err       = err_q;
endmodule

// File: tb/tb_viterbi_backtrace.sv
// tb_viterbi_backtrace
//   Directed bench for viterbi_backtrace: hand-built pointer chains, expected
//   tag streams, stalls, rejected starts, dropped writes and mid-run reset.
module tb_viterbi_backtrace;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bp_wr_en = 1'b0;
   logic [4:0] bp_wr_t = '0;
   logic [3:0] bp_wr_state = '0;
   logic [3:0] bp_wr_idx = '0;
   logic       start = 1'b0;
   logic [5:0] seq_len = '0;
   logic [3:0] last_state = '0;
   logic       busy, tag_valid, tag_last, done, err;
   logic       tag_ready = 1'b0;
   logic [3:0] tag_out;
   logic [4:0] tag_t;

   int n_tests = 0;
   int n_fail  = 0;

   viterbi_backtrace #(.POS_num_bit(4), .T_BITS(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .bp_wr_en(bp_wr_en), .bp_wr_t(bp_wr_t), .bp_wr_state(bp_wr_state), .bp_wr_idx(bp_wr_idx),
      .start(start), .seq_len(seq_len), .last_state(last_state),
      .busy(busy), .tag_valid(tag_valid), .tag_ready(tag_ready),
      .tag_out(tag_out), .tag_t(tag_t), .tag_last(tag_last),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All tasks start and end just after a negedge.
   task automatic wr_bp(input logic [4:0] t, input logic [3:0] s, input logic [3:0] idx);
      bp_wr_en = 1'b1; bp_wr_t = t; bp_wr_state = s; bp_wr_idx = idx;
      @(negedge clk);
      bp_wr_en = 1'b0;
   endtask

   task automatic pulse_start(input logic [5:0] len, input logic [3:0] last);
      start = 1'b1; seq_len = len; last_state = last;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic take_tag(input logic [3:0] exp_tag, input logic [4:0] exp_t, input int stall);
      int n;
      logic [31:0] exp_vec;
      n = 0;
      while (!tag_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!tag_valid) begin
         chk("tag_valid_timeout", 32'(tag_valid), 32'd1);
         return;
      end
      chk("tag_out", 32'(tag_out), 32'(exp_tag));
      chk("tag_t", 32'(tag_t), 32'(exp_t));
      chk("tag_last", 32'(tag_last), 32'(exp_t == 5'd0));
      exp_vec = {21'd0, 1'b1, (exp_t == 5'd0), exp_t, exp_tag};
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_stable", {21'd0, tag_valid, tag_last, tag_t, tag_out}, exp_vec);
      end
      tag_ready = 1'b1;
      @(negedge clk);
      tag_ready = 1'b0;
      if (exp_t != 5'd0) begin
         chk("fetch_valid_low", 32'(tag_valid), 32'd0);
      end else begin
         chk("done_after_last", 32'(done), 32'd1);
         chk("busy_at_done", 32'(busy), 32'd0);
         chk("valid_after_last", 32'(tag_valid), 32'd0);
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 32'd0);
      end
   endtask

   function automatic logic [3:0] tagf(input int t);
      return 4'((t * 7 + 2) & 15);
   endfunction

   task automatic load_t1();
      wr_bp(5'd3, 4'd3, 4'd7);
      wr_bp(5'd2, 4'd7, 4'd1);
      wr_bp(5'd1, 4'd1, 4'd9);
   endtask

   initial begin
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(tag_valid), 32'd0);
      chk("rst_tag_out", 32'(tag_out), 32'd0);
      chk("rst_tag_t", 32'(tag_t), 32'd0);
      chk("rst_tag_last", 32'(tag_last), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: basic chain 3,7,1,9
      load_t1();
      pulse_start(6'd4, 4'd3);
      chk("t1_latency", 32'(tag_valid), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      take_tag(4'd3, 5'd3, 0);
      take_tag(4'd7, 5'd2, 0);
      take_tag(4'd1, 5'd1, 0);
      take_tag(4'd9, 5'd0, 0);

      // 2: single-step sequence
      pulse_start(6'd1, 4'd5);
      take_tag(4'd5, 5'd0, 0);

      // 3: back-pressure
      pulse_start(6'd4, 4'd3);
      take_tag(4'd3, 5'd3, 10);
      take_tag(4'd7, 5'd2, 10);
      take_tag(4'd1, 5'd1, 10);
      take_tag(4'd9, 5'd0, 10);

      // 4: seq_len 0 and out of range
      pulse_start(6'd0, 4'd2);
      chk("t4_len0_done", 32'(done), 32'd1);
      chk("t4_len0_valid", 32'(tag_valid), 32'd0);
      chk("t4_len0_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t4_len0_done_off", 32'(done), 32'd0);
      chk("t4_len0_valid2", 32'(tag_valid), 32'd0);
      pulse_start(6'd33, 4'd2);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_err_busy", 32'(busy), 32'd0);
      chk("t4_err_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("t4_err_off", 32'(err), 32'd0);
      chk("t4_err_busy2", 32'(busy), 32'd0);

      // 5: write and start while busy are ignored
      pulse_start(6'd4, 4'd3);
      take_tag(4'd3, 5'd3, 0);
      chk("t5_busy", 32'(busy), 32'd1);
      bp_wr_en = 1'b1; bp_wr_t = 5'd2; bp_wr_state = 4'd7; bp_wr_idx = 4'hF;
      start = 1'b1; seq_len = 6'd2; last_state = 4'd0;
      @(negedge clk);
      bp_wr_en = 1'b0; start = 1'b0;
      chk("t5_no_err", 32'(err), 32'd0);
      take_tag(4'd7, 5'd2, 0);
      take_tag(4'd1, 5'd1, 0);
      take_tag(4'd9, 5'd0, 0);

      // 6: reset mid-traceback, then full-length chain
      pulse_start(6'd4, 4'd3);
      take_tag(4'd3, 5'd3, 0);
      take_tag(4'd7, 5'd2, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_valid", 32'(tag_valid), 32'd0);
      chk("t6_rst_tag_out", 32'(tag_out), 32'd0);
      chk("t6_rst_tag_t", 32'(tag_t), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_no_done", 32'(done), 32'd0);
      for (int t = 1; t < 32; t++)
         wr_bp(5'(t), tagf(t), tagf(t - 1));
      pulse_start(6'd32, tagf(31));
      for (int t = 31; t >= 0; t--)
         take_tag(tagf(t), 5'(t), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
